// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: the instruction class handed over by the decoder.
package riscv_pkg;

    typedef enum logic [4:0] {
        OP_NOP    = 5'd0,
        OP_ADD    = 5'd1,
        OP_LW     = 5'd2,
        OP_SW     = 5'd3,
        LR_W      = 5'd4,
        SC_W      = 5'd5,
        AMOSWAP_W = 5'd6,
        AMOADD_W  = 5'd7,
        AMOXOR_W  = 5'd8,
        AMOAND_W  = 5'd9,
        AMOOR_W   = 5'd10,
        AMOMIN_W  = 5'd11,
        AMOMAX_W  = 5'd12,
        AMOMINU_W = 5'd13,
        AMOMAXU_W = 5'd14
    } instr_op_e;

endpackage

// File: rtl/amo_sequencer.sv
// Multi-cycle LR/SC/AMO controller beside EX/MEM: owns the data port while busy,
// sequences read -> compute -> write and holds the LR/SC reservation.
module amo_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RSV_GRAN_LSB = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  instr_op_e       i_op,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_snoop_store,
    input  logic [XLEN-1:0] i_snoop_addr,
    input  logic            i_clear_rsv,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_misaligned,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic            i_mem_ready,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_rsv_valid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_e;

    localparam int RW = XLEN - RSV_GRAN_LSB;

    // Anything the decoder hands us that is not a known A-extension op runs as AMOADD.
    function automatic instr_op_e norm_op(input instr_op_e op);
        case (op)
            LR_W, SC_W, AMOSWAP_W, AMOADD_W, AMOXOR_W, AMOAND_W, AMOOR_W,
            AMOMIN_W, AMOMAX_W, AMOMINU_W, AMOMAXU_W: return op;
            default:                                  return AMOADD_W;
        endcase
    endfunction

    // Read-modify-write ALU; on a compare tie the memory value is kept.
    function automatic logic [XLEN-1:0] amo_alu(input instr_op_e       op,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] rs2);
        case (op)
            AMOSWAP_W: return rs2;
            AMOXOR_W:  return mem ^ rs2;
            AMOAND_W:  return mem & rs2;
            AMOOR_W:   return mem | rs2;
            AMOMIN_W:  return ($signed(rs2) < $signed(mem)) ? rs2 : mem;
            AMOMAX_W:  return ($signed(rs2) > $signed(mem)) ? rs2 : mem;
            AMOMINU_W: return (rs2 < mem) ? rs2 : mem;
            AMOMAXU_W: return (rs2 > mem) ? rs2 : mem;
            default:   return mem + rs2;
        endcase
    endfunction

    state_e          state_q,      state_d;
    instr_op_e       op_q,         op_d;
    logic [XLEN-1:0] addr_q,       addr_d;
    logic [XLEN-1:0] rs2_q,        rs2_d;
    logic [XLEN-1:0] rd_data_q,    rd_data_d;
    logic            done_q,       done_d;
    logic            misaligned_q, misaligned_d;
    logic            mem_req_q,    mem_req_d;
    logic            mem_we_q,     mem_we_d;
    logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q,  mem_wdata_d;
    logic            rsv_valid_q,  rsv_valid_d;
    logic [RW-1:0]   rsv_addr_q,   rsv_addr_d;

    instr_op_e       start_op;
    logic [XLEN-1:0] start_word_addr;
    logic            snoop_hit;
    logic            unused_lsbs;

    assign start_op        = norm_op(i_op);
    assign start_word_addr = {i_addr[XLEN-1:2], 2'b00};
    assign snoop_hit       = i_snoop_store && (i_snoop_addr[XLEN-1:RSV_GRAN_LSB] == rsv_addr_q);
    assign unused_lsbs     = ^{i_snoop_addr[RSV_GRAN_LSB-1:0], addr_q[RSV_GRAN_LSB-1:0]};

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsv_valid_d  = rsv_valid_q;
        rsv_addr_d   = rsv_addr_q;

        // External invalidation first; an LR set later in this block overrides it.
        if (i_clear_rsv || snoop_hit) begin
            rsv_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    op_d   = start_op;
                    addr_d = i_addr;
                    rs2_d  = i_rs2;
                    if (start_op == SC_W) begin
                        rsv_valid_d = 1'b0;
                    end
                    if (i_addr[1:0] != 2'b00) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                        rd_data_d    = '0;
                    end else if (start_op == SC_W) begin
                        if (rsv_valid_q && (i_addr[XLEN-1:RSV_GRAN_LSB] == rsv_addr_q)) begin
                            state_d     = WR_REQ;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = start_word_addr;
                            mem_wdata_d = i_rs2;
                        end else begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            rd_data_d = XLEN'(1);
                        end
                    end else begin
                        state_d    = RD_REQ;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = start_word_addr;
                    end
                end
            end

            RD_REQ: begin
                if (i_mem_ready) begin
                    state_d   = RD_WAIT;
                    mem_req_d = 1'b0;
                end
            end

            RD_WAIT: begin
                if (i_mem_rvalid) begin
                    rd_data_d = i_mem_rdata;
                    if (op_q == LR_W) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        rsv_valid_d = 1'b1;
                        rsv_addr_d  = addr_q[XLEN-1:RSV_GRAN_LSB];
                    end else begin
                        state_d     = WR_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = amo_alu(op_q, i_mem_rdata, rs2_q);
                    end
                end
            end

            WR_REQ: begin
                if (i_mem_ready) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (op_q == SC_W) begin
                        rd_data_d = '0;
                    end
                    if (addr_q[XLEN-1:RSV_GRAN_LSB] == rsv_addr_q) begin
                        rsv_valid_d = 1'b0;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            op_q         <= OP_NOP;
            addr_q       <= '0;
            rs2_q        <= '0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsv_valid_q  <= 1'b0;
            rsv_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsv_valid_q  <= rsv_valid_d;
            rsv_addr_q   <= rsv_addr_d;
        end
    end

    // Stall drops in DONE so the pipeline advances together with the writeback.
    assign o_stall = ((state_q == IDLE) && i_start) ||
                     (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WR_REQ);

    assign o_done       = done_q;
    assign o_rd_data    = rd_data_q;
    assign o_misaligned = misaligned_q;
    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_wstrb  = {4{mem_we_q}};
    assign o_rsv_valid  = rsv_valid_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Scoreboarded bench for amo_sequencer: directed ops push expected responses and
// memory accesses; a memory model and a done monitor pop and compare them.
module tb_amo_sequencer;
    import riscv_pkg::*;

    logic            clk;
    logic            i_rst;
    logic            i_start;
    instr_op_e       i_op;
    logic [31:0]     i_addr;
    logic [31:0]     i_rs2;
    logic            i_snoop_store;
    logic [31:0]     i_snoop_addr;
    logic            i_clear_rsv;
    logic            o_stall;
    logic            o_done;
    logic [31:0]     o_rd_data;
    logic            o_misaligned;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [31:0]     o_mem_addr;
    logic [31:0]     o_mem_wdata;
    logic [3:0]      o_mem_wstrb;
    logic            i_mem_ready;
    logic            i_mem_rvalid;
    logic [31:0]     i_mem_rdata;
    logic            o_rsv_valid;

    amo_sequencer #(.XLEN(32), .RSV_GRAN_LSB(2)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_addr       (i_addr),
        .i_rs2        (i_rs2),
        .i_snoop_store(i_snoop_store),
        .i_snoop_addr (i_snoop_addr),
        .i_clear_rsv  (i_clear_rsv),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_rd_data    (o_rd_data),
        .o_misaligned (o_misaligned),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_ready  (i_mem_ready),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_rsv_valid  (o_rsv_valid)
    );

    typedef struct {
        logic [31:0] rd;
        bit          mis;
        bit          chk_rd;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct packed {
        instr_op_e   op;
        logic [31:0] rs2;
        logic [31:0] wdata;
        logic [31:0] rd;
    } amo_vec_t;

    resp_t       resp_q[$];
    acc_t        mem_q[$];
    logic [31:0] mem [logic [31:0]];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ready_delay = 0;
    int rvalid_delay = 0;
    bit clr_on_rvalid = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 1 expected 0 (t=%0t)", name, $time);
    endtask

    task automatic exp_mem(input bit we, input logic [31:0] addr, input logic [31:0] data);
        acc_t a;
        a.we = we; a.addr = addr; a.data = data;
        mem_q.push_back(a);
    endtask

    task automatic run_op(input instr_op_e op, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rd, input bit mis, input int lat);
        resp_t r;
        int    d0;
        int    sc;
        r.rd = rd; r.mis = mis; r.chk_rd = !mis;
        resp_q.push_back(r);
        d0 = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1; i_op = op; i_addr = addr; i_rs2 = rs2;
        sc = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < 60 && done_cnt == d0; i++) begin
            @(negedge clk); #1;
        end
        if (done_cnt == d0) fail_event("done_timeout");
        else check("latency", 32'(done_cyc - sc + 1), 32'(lat));
    endtask

    task automatic pulse_snoop(input logic [31:0] addr);
        @(posedge clk); #1;
        i_snoop_store = 1'b1; i_snoop_addr = addr;
        @(posedge clk); #1;
        i_snoop_store = 1'b0;
    endtask

    // Memory model: acceptance, read-data return and request stability checks.
    initial begin
        int          wait_cnt;
        int          rd_cnt;
        logic [31:0] rd_addr;
        bit          rv_now;
        bit          rdy;
        bit          prev_hold;
        bit          prev_we;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        acc_t        e;
        wait_cnt = 0; rd_cnt = 0; rd_addr = 0; prev_hold = 0;
        prev_we = 0; prev_addr = 0; prev_wdata = 0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            rv_now = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) rv_now = 1;
            end
            i_mem_rvalid = rv_now;
            i_mem_rdata  = rv_now ? mem[rd_addr] : 32'h0;
            if (clr_on_rvalid) i_clear_rsv = rv_now;
            if (prev_hold) begin
                check("req_hold", {29'h0, o_mem_req, o_mem_we, o_stall}, {29'h0, 1'b1, prev_we, 1'b1});
                check("addr_hold", o_mem_addr, prev_addr);
                if (prev_we) check("wdata_hold", o_mem_wdata, prev_wdata);
            end
            rdy = 0;
            if (o_mem_req === 1'b1) begin
                if (wait_cnt < ready_delay) begin
                    wait_cnt++;
                end else begin
                    rdy = 1;
                    wait_cnt = 0;
                    if (mem_q.size() == 0) begin
                        fail_event("unexpected_mem_req");
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_we", {31'h0, o_mem_we}, {31'h0, e.we});
                        check("mem_addr", o_mem_addr, e.addr);
                        check("mem_wstrb", {28'h0, o_mem_wstrb}, e.we ? 32'hF : 32'h0);
                        if (e.we) check("mem_wdata", o_mem_wdata, e.data);
                    end
                    if (o_mem_we) begin
                        mem[o_mem_addr] = o_mem_wdata;
                    end else begin
                        rd_addr = o_mem_addr;
                        rd_cnt  = rvalid_delay + 1;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
            i_mem_ready = rdy;
            prev_hold  = (o_mem_req === 1'b1) && !rdy;
            prev_we    = o_mem_we;
            prev_addr  = o_mem_addr;
            prev_wdata = o_mem_wdata;
        end
    end

    // Completion monitor: every o_done pops one expected response.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                check("stall_in_done", {31'h0, o_stall}, 32'h0);
                if (resp_q.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    r = resp_q.pop_front();
                    check("misaligned", {31'h0, o_misaligned}, {31'h0, r.mis});
                    if (r.chk_rd) check("rd_data", o_rd_data, r.rd);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    amo_vec_t vecs [10];

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_op = OP_NOP; i_addr = '0; i_rs2 = '0;
        i_snoop_store = 1'b0; i_snoop_addr = '0; i_clear_rsv = 1'b0;
        mem[32'h100] = 32'h5;
        mem[32'h040] = 32'hFFFF_FFFF;
        mem[32'h048] = 32'h0000_000F;
        mem[32'h200] = 32'h11;
        vecs = '{
            '{AMOXOR_W,  32'h0000_00FF, 32'h0000_00F0, 32'h0000_000F},
            '{AMOAND_W,  32'h0000_0030, 32'h0000_0030, 32'h0000_00F0},
            '{AMOOR_W,   32'h0000_000C, 32'h0000_003C, 32'h0000_0030},
            '{AMOSWAP_W, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_003C},
            '{AMOMIN_W,  32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{AMOMINU_W, 32'h0000_0001, 32'h0000_0001, 32'hDEAD_BEEF},
            '{AMOADD_W,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
            '{OP_LW,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
            '{AMOMAXU_W, 32'h8000_0000, 32'h8000_0000, 32'h0000_0005},
            '{AMOMIN_W,  32'h0000_0005, 32'h8000_0000, 32'h8000_0000}
        };

        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {24'h0, o_done, o_misaligned, o_mem_req, o_mem_we, o_mem_wstrb},
              32'h0);
        check("reset_rd_data", o_rd_data, 32'h0);
        check("reset_stall_rsv", {30'h0, o_stall, o_rsv_valid}, 32'h0);

        exp_mem(0, 32'h100, 0);
        exp_mem(1, 32'h100, 32'h8);
        run_op(AMOADD_W, 32'h100, 32'h3, 32'h5, 0, 5);
        check("mem_0x100", mem[32'h100], 32'h8);

        exp_mem(0, 32'h40, 0);
        exp_mem(1, 32'h40, 32'h1);
        run_op(AMOMAX_W, 32'h40, 32'h1, 32'hFFFF_FFFF, 0, 5);
        mem[32'h040] = 32'hFFFF_FFFF;
        exp_mem(0, 32'h40, 0);
        exp_mem(1, 32'h40, 32'hFFFF_FFFF);
        run_op(AMOMAXU_W, 32'h40, 32'h1, 32'hFFFF_FFFF, 0, 5);

        for (int k = 0; k < 10; k++) begin
            exp_mem(0, 32'h48, 0);
            exp_mem(1, 32'h48, vecs[k].wdata);
            run_op(vecs[k].op, 32'h48, vecs[k].rs2, vecs[k].rd, 0, 5);
        end

        exp_mem(0, 32'h200, 0);
        run_op(LR_W, 32'h200, 32'h0, 32'h11, 0, 4);
        check("rsv_after_lr", {31'h0, o_rsv_valid}, 32'h1);
        exp_mem(1, 32'h200, 32'hAA);
        run_op(SC_W, 32'h200, 32'hAA, 32'h0, 0, 3);
        check("rsv_after_sc", {31'h0, o_rsv_valid}, 32'h0);
        run_op(SC_W, 32'h200, 32'hBB, 32'h1, 0, 2);

        exp_mem(0, 32'h200, 0);
        run_op(LR_W, 32'h200, 32'h0, 32'hAA, 0, 4);
        pulse_snoop(32'h202);
        check("rsv_snoop_hit", {31'h0, o_rsv_valid}, 32'h0);
        run_op(SC_W, 32'h200, 32'h55, 32'h1, 0, 2);

        exp_mem(0, 32'h200, 0);
        run_op(LR_W, 32'h200, 32'h0, 32'hAA, 0, 4);
        pulse_snoop(32'h204);
        check("rsv_snoop_miss", {31'h0, o_rsv_valid}, 32'h1);
        exp_mem(1, 32'h200, 32'h55);
        run_op(SC_W, 32'h200, 32'h55, 32'h0, 0, 3);

        clr_on_rvalid = 1;
        exp_mem(0, 32'h200, 0);
        run_op(LR_W, 32'h200, 32'h0, 32'h55, 0, 4);
        clr_on_rvalid = 0;
        i_clear_rsv = 1'b0;
        check("rsv_lr_beats_clear", {31'h0, o_rsv_valid}, 32'h1);
        run_op(AMOSWAP_W, 32'h103, 32'h9, 32'h0, 1, 2);
        check("rsv_after_misaligned", {31'h0, o_rsv_valid}, 32'h1);
        @(posedge clk); #1 i_clear_rsv = 1'b1;
        @(posedge clk); #1 i_clear_rsv = 1'b0;
        check("rsv_clear_pulse", {31'h0, o_rsv_valid}, 32'h0);

        ready_delay = 6;
        exp_mem(0, 32'h100, 0);
        exp_mem(1, 32'h100, 32'hA);
        run_op(AMOADD_W, 32'h100, 32'h2, 32'h8, 0, 17);
        ready_delay = 0;

        rvalid_delay = 3;
        exp_mem(0, 32'h100, 0);
        @(posedge clk); #1;
        i_start = 1'b1; i_op = AMOADD_W; i_addr = 32'h100; i_rs2 = 32'h1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(posedge clk); #1;
        check("rd_wait_state", {30'h0, o_stall, o_mem_req}, 32'h2);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        check("abort_idle", {29'h0, o_stall, o_mem_req, o_done}, 32'h0);
        repeat (8) @(posedge clk);
        #1 rvalid_delay = 0;
        check("abort_no_done", 32'(resp_q.size()), 32'h0);

        exp_mem(0, 32'h100, 0);
        exp_mem(1, 32'h100, 32'hB);
        run_op(AMOADD_W, 32'h100, 32'h1, 32'hA, 0, 5);

        repeat (3) @(posedge clk);
        check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
